// File: rtl/k12a_spi_slave.sv
// SPI mode-0 responder with oversampled pins, one-byte rx/tx buffers and sticky error flags.
// Latency: miso moves SYNC_STAGES+1 clocks after the sck fall at the pin; rx_valid rises SYNC_STAGES+1 clocks after the 8th sck rise.
// Backpressure: none on the wire; an unread rx byte is overwritten (rx_overrun), an empty tx buffer sends IDLE_BYTE (tx_underrun). Optional: K12A_SPI_SLAVE_FRAME_COUNT_EN.
module k12a_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       err_clear
`ifdef K12A_SPI_SLAVE_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_bytes
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
  logic                   sck_d, ss_d;
  logic                   sck_s, mosi_s, ss_s;
  logic                   sck_rise, sck_fall, ss_fall, ss_rise;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift, tx_buf;
  logic                   tx_full;
  logic                   frame_start, frame_end, shift_in, shift_out, tx_consume, byte_done;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_fall  = ~ss_s & ss_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign tx_ready = ~tx_full;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ss_rise outranks a coincident sck edge, so a master that drops sck and
  // releases ss together ends the frame without a trailing tx reload.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    tx_consume  = 1'b0;
    byte_done   = 1'b0;
    spi_miso    = 1'b0;
    spi_miso_oe = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
          tx_consume  = 1'b1;
        end
      end
      ACTIVE: begin
        spi_miso    = tx_shift[7];
        spi_miso_oe = 1'b1;
        if (ss_rise) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else if (sck_rise) begin
          shift_in  = 1'b1;
          byte_done = (bit_cnt == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt == 3'd0) tx_consume = 1'b1;
          else                 shift_out  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      tx_buf      <= 8'h00;
      tx_full     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (frame_start || frame_end) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
      end else if (shift_in) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[6:0], mosi_s};
      end

      if (frame_end)       tx_shift <= 8'h00;
      else if (tx_consume) tx_shift <= tx_full ? tx_buf : IDLE_BYTE;
      else if (shift_out)  tx_shift <= {tx_shift[6:0], 1'b0};

      // A load in the same cycle as consumption refills the freed slot.
      if (tx_consume)               tx_full <= tx_load;
      else if (tx_load && !tx_full) tx_full <= 1'b1;
      if (tx_load && (tx_consume || !tx_full)) tx_buf <= tx_data;

      if (byte_done) begin
        rx_data  <= {rx_shift[6:0], mosi_s};
        rx_valid <= 1'b1;
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end

      if (byte_done && rx_valid && !rx_read) rx_overrun <= 1'b1;
      else if (err_clear)                    rx_overrun <= 1'b0;

      if (tx_consume && !tx_full) tx_underrun <= 1'b1;
      else if (err_clear)         tx_underrun <= 1'b0;
    end
  end

`ifdef K12A_SPI_SLAVE_FRAME_COUNT_EN
  always_ff @(posedge cpu_clock) begin
    if (reset || frame_start)                frame_bytes <= 8'h00;
    else if (byte_done && frame_bytes != 8'hFF) frame_bytes <= frame_bytes + 8'h01;
  end
`endif

endmodule

// File: tb/tb_k12a_spi_slave.sv
// Bench for k12a_spi_slave: directed vector table, hand-written corner sequences and randomized frames vs a frame-level model.
module tb_k12a_spi_slave;
  typedef logic [7:0] u8;
  localparam int SS = 2;

  logic       cpu_clock = 1'b0;
  logic       reset, spi_sck, spi_mosi, spi_ss_n, rx_read, tx_load, err_clear;
  logic [7:0] tx_data;
  logic       spi_miso, spi_miso_oe, rx_valid, tx_ready, rx_overrun, tx_underrun;
  logic [7:0] rx_data;
`ifdef K12A_SPI_SLAVE_FRAME_COUNT_EN
  logic [7:0] frame_bytes;
`endif

  k12a_spi_slave #(.SYNC_STAGES(SS), .IDLE_BYTE(8'hFF)) dut (
    .cpu_clock(cpu_clock), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_ss_n(spi_ss_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read), .tx_data(tx_data),
    .tx_load(tx_load), .tx_ready(tx_ready), .rx_overrun(rx_overrun),
    .tx_underrun(tx_underrun), .err_clear(err_clear)
`ifdef K12A_SPI_SLAVE_FRAME_COUNT_EN
    , .frame_bytes(frame_bytes)
`endif
  );

  always #5 cpu_clock = ~cpu_clock;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  auto_read = 0, auto_load = 0, force_read = 0;
  u8   load_q[$];
  u8   got_q[$];

  typedef struct {
    int          n;    logic [31:0] mo;   bit pre;  u8 pv;
    int          nq;   logic [31:0] q;    bit rd;
    logic [31:0] em;   u8 erx;  bit ev;   bit eu;   bit eo;  bit er;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of host behaviour: optional auto-read of rx and auto-refill of tx.
  task automatic tick();
    @(posedge cpu_clock); #1;
    tx_load = 1'b0;
    if (auto_load && tx_ready && load_q.size() > 0) begin
      tx_data = load_q.pop_front();
      tx_load = 1'b1;
    end
    if (auto_read && !rx_read && rx_valid) begin
      got_q.push_back(rx_data);
      rx_read = 1'b1;
    end else begin
      rx_read = force_read;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    force_read = 1; tick(); force_read = 0; tick();
    got_q = {};
  endtask

  task automatic clear_and_check(input string tag);
    err_clear = 1; tick(); err_clear = 0;
    check({tag, "_clr_over"}, rx_overrun, 0);
    check({tag, "_clr_under"}, tx_underrun, 0);
  endtask

  task automatic preload(input u8 v);
    tx_data = v; tx_load = 1; tick();
  endtask

  // Mode-0 master; the final sck fall and ss release happen together.
  task automatic run_frame(input u8 mo[$], input int h, input int abort_rises,
                           input bit force_last, output u8 mi[$]);
    u8  m;
    int rises;
    bit last;
    mi = {}; rises = 0; last = 0;
    spi_ss_n = 0;
    for (int i = 0; i < mo.size(); i++) begin
      m = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        spi_mosi = mo[i][b];
        ticks(h);
        m = {m[6:0], spi_miso};
        spi_sck = 1; auto_load = 1; rises++;
        last = (abort_rises > 0) ? (rises == abort_rises) : (i == mo.size() - 1 && b == 0);
        if (force_last && last) begin
          ticks(SS - 1); force_read = 1; tick(); force_read = 0; tick(); ticks(h - SS - 1);
        end else begin
          ticks(h);
        end
        spi_sck = 0;
        if (last) begin spi_ss_n = 1; auto_load = 0; break; end
      end
      mi.push_back(m);
      if (last) break;
    end
    spi_mosi = 0;
    ticks(2 * h + 4);
  endtask

  task automatic check_fb(input string name, input int exp);
`ifdef K12A_SPI_SLAVE_FRAME_COUNT_EN
    check(name, frame_bytes, exp);
`else
    check(name, spi_miso_oe, 0);
`endif
  endtask

  initial begin
    u8   mo[$];
    u8   mi[$];
    u8   exp_mi[4];
    u8   qv[4];
    bit  mdl_full, eu;
    u8   mdl_val;
    int  n, h, nq;

    reset = 1; spi_sck = 0; spi_mosi = 0; spi_ss_n = 1; rx_read = 0;
    tx_load = 0; tx_data = 0; err_clear = 0;
    ticks(3);
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_flags", {rx_overrun, tx_underrun}, 0);
    reset = 0; ticks(4);

    //          n  mosi         pre pv     nq q       rd expected miso rx     valid und ovr rdy
    tbl[0] = '{1, 32'h3C,      1, 8'hA5, 0, 32'h0,  0, 32'hA5,     8'h3C, 1, 0, 0, 1};
    tbl[1] = '{2, 32'h2211,    1, 8'h01, 1, 32'h02, 1, 32'h0201,   8'h22, 0, 0, 0, 1};
    tbl[2] = '{2, 32'hA55A,    0, 8'h00, 0, 32'h0,  1, 32'hFFFF,   8'hA5, 0, 1, 0, 1};
    tbl[3] = '{2, 32'h55AA,    1, 8'h77, 1, 32'h88, 0, 32'h8877,   8'h55, 1, 0, 1, 1};

    for (int v = 0; v < 4; v++) begin
      drain();
      if (tbl[v].pre) preload(tbl[v].pv);
      load_q = {};
      for (int k = 0; k < tbl[v].nq; k++) load_q.push_back(tbl[v].q[8*k +: 8]);
      mo = {};
      for (int k = 0; k < tbl[v].n; k++) mo.push_back(tbl[v].mo[8*k +: 8]);
      auto_read = tbl[v].rd;
      run_frame(mo, 8, 0, 0, mi);
      for (int k = 0; k < tbl[v].n; k++)
        check($sformatf("v%0d_miso%0d", v, k), mi[k], tbl[v].em[8*k +: 8]);
      if (tbl[v].rd) begin
        check($sformatf("v%0d_nread", v), got_q.size(), tbl[v].n);
        for (int k = 0; k < got_q.size() && k < tbl[v].n; k++)
          check($sformatf("v%0d_host%0d", v, k), got_q[k], tbl[v].mo[8*k +: 8]);
      end
      check($sformatf("v%0d_rx_data", v), rx_data, tbl[v].erx);
      check($sformatf("v%0d_rx_valid", v), rx_valid, tbl[v].ev);
      check($sformatf("v%0d_underrun", v), tx_underrun, tbl[v].eu);
      check($sformatf("v%0d_overrun", v), rx_overrun, tbl[v].eo);
      check($sformatf("v%0d_tx_ready", v), tx_ready, tbl[v].er);
      check_fb($sformatf("v%0d_frame_bytes", v), tbl[v].n);
      auto_read = 0; load_q = {};
      clear_and_check($sformatf("v%0d", v));
    end

    // rx_read on exactly the completion cycle of the second byte
    drain();
    mo = {8'hAA, 8'h55};
    run_frame(mo, 8, 0, 1, mi);
    check("coinc_rx_valid", rx_valid, 1);
    check("coinc_rx_data", rx_data, 8'h55);
    check("coinc_overrun", rx_overrun, 0);
    clear_and_check("coinc");

    // aborted frame after 5 rises, then a clean frame
    drain();
    mo = {8'hB7};
    run_frame(mo, 8, 5, 0, mi);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_oe", spi_miso_oe, 0);
    check_fb("abort_frame_bytes", 0);
    mo = {8'hC3};
    run_frame(mo, 8, 0, 0, mi);
    check("after_abort_rx_data", rx_data, 8'hC3);
    check("after_abort_rx_valid", rx_valid, 1);
    check("after_abort_miso", mi[0], 8'hFF);

    // reset after three sck edges with rx_valid and tx_underrun still set
    load_q = {8'h5E};
    spi_ss_n = 0; spi_mosi = 1; ticks(8);
    spi_sck = 1; auto_load = 1; ticks(8);
    spi_sck = 0; ticks(8);
    spi_sck = 1; ticks(8);
    auto_load = 0; load_q = {};
    check("pre_rst_oe", spi_miso_oe, 1);
    check("pre_rst_tx_ready", tx_ready, 0);
    reset = 1; tick();
    check("mid_rst_miso", spi_miso, 0);
    check("mid_rst_oe", spi_miso_oe, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_flags", {rx_overrun, tx_underrun}, 0);
    check_fb("mid_rst_frame_bytes", 0);
    spi_sck = 0; spi_ss_n = 1; spi_mosi = 0; ticks(4);
    reset = 0; ticks(4);
    preload(8'hA5);
    mo = {8'h3C};
    run_frame(mo, 8, 0, 0, mi);
    check("post_rst_miso", mi[0], 8'hA5);
    check("post_rst_rx_data", rx_data, 8'h3C);
    check("post_rst_rx_valid", rx_valid, 1);
    check("post_rst_flags", {rx_overrun, tx_underrun}, 0);

    // randomized frames: the tx stream is buffer-or-preload, then queued loads, else idle byte
    mdl_full = 0; mdl_val = 0;
    for (int r = 0; r < 12; r++) begin
      n  = $urandom_range(1, 4);
      h  = $urandom_range(SS + 2, 10);
      nq = $urandom_range(0, 4);
      drain();
      err_clear = 1; tick(); err_clear = 0;
      if (!mdl_full && ($urandom % 2 == 1)) begin
        mdl_val = u8'($urandom); mdl_full = 1; preload(mdl_val);
      end
      load_q = {};
      for (int k = 0; k < 4; k++) qv[k] = u8'($urandom);
      for (int k = 0; k < nq; k++) load_q.push_back(qv[k]);
      mo = {};
      for (int k = 0; k < n; k++) mo.push_back(u8'($urandom));
      exp_mi[0] = mdl_full ? mdl_val : 8'hFF;
      eu = !mdl_full;
      for (int k = 1; k < n; k++) begin
        if (k - 1 < nq) exp_mi[k] = qv[k-1];
        else begin exp_mi[k] = 8'hFF; eu = 1; end
      end
      mdl_full = (nq >= n);
      if (mdl_full) mdl_val = qv[n-1];
      auto_read = 1;
      run_frame(mo, h, 0, 0, mi);
      for (int k = 0; k < n; k++) begin
        check($sformatf("r%0d_miso%0d", r, k), mi[k], exp_mi[k]);
        check($sformatf("r%0d_host%0d", r, k), (k < got_q.size()) ? got_q[k] : 32'hDEAD, mo[k]);
      end
      check($sformatf("r%0d_nread", r), got_q.size(), n);
      check($sformatf("r%0d_underrun", r), tx_underrun, eu);
      check($sformatf("r%0d_overrun", r), rx_overrun, 0);
      check($sformatf("r%0d_tx_ready", r), tx_ready, !mdl_full);
      check_fb($sformatf("r%0d_frame_bytes", r), n);
      auto_read = 0; load_q = {};
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/k12a_spi_slave.md
Name: k12a_spi_slave

Overview:
- SPI responder (mode 0, MSB first): the far end of the k12a SPI master ports (sck/mosi/miso).
- Lets a k12a-style core act as a peripheral, or serves as a synthesizable loopback target for the spi0/spi1 masters.
- Oversamples sck/mosi/ss_n in the cpu_clock domain, deserialises received bytes and serialises a one-byte transmit buffer.
- Holds a byte-level host handshake with sticky error flags.

Parameters:
SYNC_STAGES, 2, flops in each input synchroniser (legal range 2-4)
IDLE_BYTE, 8'hFF, byte shifted out when no tx byte is loaded at a byte boundary

Ports:
cpu_clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
spi_sck  input  1  SPI clock from master (async)
spi_mosi  input  1  master-out data (async)
spi_ss_n  input  1  active-low slave select (async)
spi_miso  output  1  slave-out data; 0 when not selected
spi_miso_oe  output  1  1 while selected (for external tristate)
rx_data  output  8  last complete received byte
rx_valid  output  1  rx_data holds an unread byte
rx_read  input  1  host acknowledge; clears rx_valid
tx_data  input  8  byte to transmit
tx_load  input  1  write tx_data into tx buffer
tx_ready  output  1  tx buffer empty (=~tx_full)
rx_overrun  output  1  sticky: byte completed while rx_valid set and not read
tx_underrun  output  1  sticky: IDLE_BYTE sent because buffer empty
err_clear  input  1  clears both sticky flags

Behaviour:
- Reset (synchronous, active-high; applies mid-frame too): state IDLE, all shift regs/counters 0, tx_full=0, rx_data=0, rx_valid=0, flags=0, spi_miso=0, spi_miso_oe=0, synchronisers preset to sck=0, mosi=0, ss_n=1.
- Synchronisers: SYNC_STAGES flops plus one history flop per input; sck_rise/sck_fall/ss_fall/ss_rise are one-cycle pulses.
- Timing requirement: each sck half-period >= SYNC_STAGES+2 cpu_clock cycles. spi_miso changes SYNC_STAGES+1 cycles after the pin-level sck fall.
- FSM IDLE -> ACTIVE on ss_fall:
  - bit_cnt=0; tx_shift loaded from buffer if tx_full (tx_full cleared), else loaded with IDLE_BYTE and tx_underrun set.
- ACTIVE, sck_rise:
  - rx_shift={rx_shift[6:0],mosi_s}; bit_cnt increments mod 8.
  - When bit_cnt was 7: rx_data={rx_shift[6:0],mosi_s}, rx_valid=1. If rx_valid was already 1 and rx_read is not asserted this cycle, rx_overrun=1; the new byte overwrites the old.
- ACTIVE, sck_fall:
  - bit_cnt==0 (byte boundary): reload tx_shift using the same rule as at ss_fall.
  - Otherwise: tx_shift shifts left one bit.
- ACTIVE -> IDLE on ss_rise: partial rx bits discarded, bit_cnt=0, no rx_valid, tx_shift dropped, buffered tx byte retained.
- spi_miso = tx_shift[7] in ACTIVE, 0 in IDLE. spi_miso_oe = (state==ACTIVE).
- sck edges in IDLE are ignored.
- rx_read with rx_valid=0 has no effect.
- rx_read coincident with byte completion: rx_valid stays 1 with the new data, no overrun.
- tx_load with tx_full=1 is ignored (buffer unchanged).
- tx_load coincident with buffer consumption: old byte is consumed, new byte is stored, tx_full stays 1.
- err_clear coincident with a flag-setting event: the set wins.

Optional Feature:
- Macro: K12A_SPI_SLAVE_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_bytes[7:0], the count of complete bytes received since the last ss_fall.
  - Cleared on ss_fall and reset; increments on each byte completion; saturates at 8'hFF.
  - Holds its value after ss_rise until the next ss_fall.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic byte: load tx 8'hA5; master sends 8'h3C with sck half-period 8 cycles -> master reads 8'hA5, rx_data=8'h3C, rx_valid=1, no flags set.
- Multi-byte with host servicing: preload 8'h01, and load 8'h02 while tx_ready=1 during the first byte; master sends 8'h11, 8'h22 -> master reads 01, 02; host sees 11 then 22; frame_bytes=2 when the feature is enabled.
- Underrun: no tx load; master clocks 2 bytes -> master reads FF, FF; tx_underrun=1; err_clear -> 0.
- Overrun: rx_read never asserted across 2 bytes (8'hAA, 8'h55) -> rx_data=8'h55, rx_overrun=1. Repeat with rx_read on the completion cycle -> rx_overrun=0.
- Aborted frame: ss_n deasserted after 5 rising edges -> rx_valid stays 0; the next full frame sending 8'hC3 yields rx_data=8'hC3.
- Reset mid-byte: assert reset after 3 sck edges -> all outputs at reset values, spi_miso_oe=0; a subsequent frame behaves as in the basic byte test.
